// File: rtl/xilinx_exit_status_uart_tx.sv
// Purpose: serialize the MCU exit value as a 6-byte 8N1 UART frame (SYNC, V[7:0]..V[31:24], XOR checksum).
// Latency: start bit on the line one cycle after the exit_valid_i rising edge; frame lasts 60*CLKS_PER_BIT cycles.
// Backpressure: none; one pending slot absorbs a trigger while busy, newer triggers overwrite it and set overrun_o.
module xilinx_exit_status_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o,
  output logic [7:0]  frame_count_o
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] baud_q, baud_nxt;
  logic [2:0]    bit_q, bit_nxt;
  logic [2:0]    byte_q, byte_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic [31:0]   cur_q, cur_nxt;
  logic [31:0]   pend_val_q, pend_val_nxt;
  logic          pend_vld_q, pend_vld_nxt;
  logic          prev_q;
  logic          done_q, done_nxt;
  logic          overrun_q, overrun_nxt;
  logic [7:0]    count_q, count_nxt;
  logic          tx_q, tx_nxt;
  logic          trig;
  logic          baud_done;

  // Byte idx of the frame: sync, the four value bytes LSB first, then their XOR.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] v);
    logic [7:0] b;
    case (idx)
      3'd1:    b = v[7:0];
      3'd2:    b = v[15:8];
      3'd3:    b = v[23:16];
      3'd4:    b = v[31:24];
      3'd5:    b = v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

  assign trig      = exit_valid_i & ~prev_q;
  assign baud_done = (baud_q == BAUD_LAST);

  // Next-state, datapath and line level; the line is registered so the pin never glitches.
  always_comb begin
    state_nxt    = state_q;
    baud_nxt     = baud_q;
    bit_nxt      = bit_q;
    byte_nxt     = byte_q;
    shift_nxt    = shift_q;
    cur_nxt      = cur_q;
    pend_val_nxt = pend_val_q;
    pend_vld_nxt = pend_vld_q;
    overrun_nxt  = overrun_q;
    count_nxt    = count_q;
    done_nxt     = 1'b0;
    tx_nxt       = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (trig || pend_vld_q) begin
          state_nxt = START;
          baud_nxt  = '0;
          byte_nxt  = 3'd0;
          shift_nxt = SYNC_BYTE;
          if (pend_vld_q) begin
            // Older pending value goes first; a same-cycle trigger refills the slot.
            cur_nxt = pend_val_q;
            if (trig) pend_val_nxt = exit_value_i;
            else      pend_vld_nxt = 1'b0;
          end else begin
            cur_nxt = exit_value_i;
          end
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
        end else begin
          baud_nxt  = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_nxt = STOP;
          else               bit_nxt   = bit_q + 3'd1;
        end else begin
          baud_nxt  = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (byte_q != LAST_BYTE) begin
            state_nxt = START;
            byte_nxt  = byte_q + 3'd1;
            shift_nxt = frame_byte(byte_q + 3'd1, cur_q);
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            count_nxt = count_q + 8'd1;
          end
        end else begin
          baud_nxt = baud_q + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A trigger while a frame is in flight lands in the single pending slot.
    if (state_q != IDLE && trig) begin
      pend_val_nxt = exit_value_i;
      pend_vld_nxt = 1'b1;
      if (pend_vld_q) overrun_nxt = 1'b1;
    end

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset returns the line high and drops any frame in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 3'd0;
      shift_q    <= 8'd0;
      cur_q      <= 32'd0;
      pend_val_q <= 32'd0;
      pend_vld_q <= 1'b0;
      prev_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      baud_q     <= baud_nxt;
      bit_q      <= bit_nxt;
      byte_q     <= byte_nxt;
      shift_q    <= shift_nxt;
      cur_q      <= cur_nxt;
      pend_val_q <= pend_val_nxt;
      pend_vld_q <= pend_vld_nxt;
      prev_q     <= exit_valid_i;
      done_q     <= done_nxt;
      overrun_q  <= overrun_nxt;
      count_q    <= count_nxt;
      tx_q       <= tx_nxt;
    end
  end

  assign uart_tx_o     = tx_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign overrun_o     = overrun_q;
  assign frame_count_o = count_q;

endmodule
